syncram_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one 16x8 synchronous RAM (syncram) among N_REQ requesters.

---
 rtl/syncram_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/syncram_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/syncram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : syncram_pkg
//  Brief    : Shared sizes and FSM encoding for the syncram arbiter slice.
//  Revision : 1.0  initial release
// ============================================================================
package syncram_pkg;

    localparam int AW_DEFAULT = 4;
    localparam int DW_DEFAULT = 8;
    localparam int RAM_DEPTH  = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin pick; search starts at ptr and wraps.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic w_found;
    int   w_pos;

    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int i = 0; i < N; i++) begin
            w_pos = (int'(ptr) + i) % N;
            if (!w_found && req[w_pos]) begin
                grant[w_pos] = 1'b1;
                idx          = w_pos[IW-1:0];
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/syncram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : syncram_arbiter
//  Brief    : Round-robin sequencer sharing one synchronous RAM among N_REQ
//             requesters; sole driver of the RAM control pins.
//  Revision : 1.0  initial release
// ============================================================================
module syncram_arbiter
    import syncram_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_write,
    input  logic [AW*N_REQ-1:0] req_addr,
    input  logic [DW*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_rdata,
    output logic                ram_rst,
    output logic                ram_we,
    output logic                ram_re,
    output logic [AW-1:0]       ram_waddr,
    output logic [AW-1:0]       ram_raddr,
    output logic [DW-1:0]       ram_din,
    input  logic [DW-1:0]       ram_dout
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [1:0]       r_state;
    logic [IW-1:0]    r_ptr;
    logic [N_REQ-1:0] r_grant;
    logic             r_write;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;

    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_idx;
    logic [IW-1:0]    w_next_ptr;
    logic             w_accept;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign req_ready  = (r_state == ST_IDLE && !rst) ? w_grant : '0;
    assign w_accept   = |(req_valid & req_ready);
    assign w_next_ptr = (int'(w_idx) >= N_REQ - 1) ? '0 : w_idx + 1'b1;

    // Both addresses always follow the latched address: with we=re=0 the RAM
    // copies mem[raddr] to mem[waddr], which is then a harmless self-copy.
    assign ram_rst   = rst;
    assign ram_we    = !rst && (r_state == ST_ISSUE) &&  r_write;
    assign ram_re    = !rst && (r_state == ST_ISSUE) && !r_write;
    assign ram_waddr = r_addr;
    assign ram_raddr = r_addr;
    assign ram_din   = r_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_grant <= w_grant;
                        r_write <= req_write[w_idx];
                        r_addr  <= req_addr[int'(w_idx)*AW +: AW];
                        r_wdata <= req_wdata[int'(w_idx)*DW +: DW];
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= r_write ? ST_IDLE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rsp_rdata <= ram_dout;
                    rsp_valid <= r_grant;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
